// File: rtl/ctrl_pkg.sv
// Shared encodings and control-bundle types for the MIPS pipeline control unit.
// CTRL_BRANCH_EN adds the beq/bne branch fields to the EX bundle.
package ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnSrl = 6'h02;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnNor = 6'h27;

  localparam logic [3:0] AluAdd = 4'h0;
  localparam logic [3:0] AluSub = 4'h1;
  localparam logic [3:0] AluSll = 4'h2;
  localparam logic [3:0] AluSrl = 4'h3;
  localparam logic [3:0] AluAnd = 4'h8;
  localparam logic [3:0] AluOr  = 4'h9;
  localparam logic [3:0] AluNor = 4'hD;

  localparam logic [1:0] MuxBRt    = 2'd0;
  localparam logic [1:0] MuxBImm   = 2'd1;
  localparam logic [1:0] MuxBShamt = 2'd2;
  localparam logic       DestRd    = 1'b0;
  localparam logic       DestRt    = 1'b1;
  localparam logic       WbMem     = 1'b0;
  localparam logic       WbAlu     = 1'b1;
  localparam logic [1:0] PcPlus4   = 2'd0;
  localparam logic [1:0] PcJump    = 2'd1;
  localparam logic [1:0] PcBranch  = 2'd2;

  typedef struct packed {
    logic [1:0] mux_1;
    logic       mux_3;
    logic [3:0] sel_alu;
    logic       illegal;
`ifdef CTRL_BRANCH_EN
    logic       is_branch;
    logic       branch_ne;
`endif
  } ex_ctrl_t;

  typedef struct packed {
    logic rd;
    logic wr;
  } mem_ctrl_t;

  typedef struct packed {
    logic mux_2;
    logic banco_wr;
  } wb_ctrl_t;

  typedef struct packed {
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } mem_stage_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ctrl_bundle_t;

  typedef enum logic [0:0] {StRun, StStall} ctrl_state_e;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode/funct to control-bundle table; unknown encodings yield a NOP
// bundle flagged illegal. Branch opcodes decode only with CTRL_BRANCH_EN.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output ctrl_bundle_t bundle,
  output logic         reads_rs,
  output logic         reads_rt,
  output logic         is_jump
);

  always_comb begin
    bundle   = '0;
    reads_rs = 1'b1;
    reads_rt = 1'b0;
    is_jump  = 1'b0;
    case (opcode)
      OpRtype: begin
        reads_rt             = 1'b1;
        bundle.ex.mux_3      = DestRd;
        bundle.wb.mux_2      = WbAlu;
        bundle.wb.banco_wr   = 1'b1;
        case (funct)
          FnAdd: bundle.ex.sel_alu = AluAdd;
          FnSub: bundle.ex.sel_alu = AluSub;
          FnAnd: bundle.ex.sel_alu = AluAnd;
          FnOr:  bundle.ex.sel_alu = AluOr;
          FnNor: bundle.ex.sel_alu = AluNor;
          FnSll: begin
            bundle.ex.sel_alu = AluSll;
            bundle.ex.mux_1   = MuxBShamt;
          end
          FnSrl: begin
            bundle.ex.sel_alu = AluSrl;
            bundle.ex.mux_1   = MuxBShamt;
          end
          default: begin
            bundle            = '0;
            bundle.ex.illegal = 1'b1;
          end
        endcase
      end
      OpAddi, OpAndi, OpOri: begin
        bundle.ex.mux_1    = MuxBImm;
        bundle.ex.mux_3    = DestRt;
        bundle.ex.sel_alu  = (opcode == OpAddi) ? AluAdd : (opcode == OpAndi) ? AluAnd : AluOr;
        bundle.wb.mux_2    = WbAlu;
        bundle.wb.banco_wr = 1'b1;
      end
      OpLw: begin
        bundle.ex.mux_1    = MuxBImm;
        bundle.ex.mux_3    = DestRt;
        bundle.ex.sel_alu  = AluAdd;
        bundle.mem.rd      = 1'b1;
        bundle.wb.mux_2    = WbMem;
        bundle.wb.banco_wr = 1'b1;
      end
      OpSw: begin
        reads_rt          = 1'b1;
        bundle.ex.mux_1   = MuxBImm;
        bundle.ex.mux_3   = DestRt;
        bundle.ex.sel_alu = AluAdd;
        bundle.mem.wr     = 1'b1;
      end
      OpJ: begin
        reads_rs = 1'b0;
        is_jump  = 1'b1;
      end
`ifdef CTRL_BRANCH_EN
      OpBeq, OpBne: begin
        reads_rt            = 1'b1;
        bundle.ex.mux_1     = MuxBRt;
        bundle.ex.sel_alu   = AluSub;
        bundle.ex.is_branch = 1'b1;
        bundle.ex.branch_ne = (opcode == OpBne);
      end
`endif
      default: bundle.ex.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// MIPS 5-stage pipeline control: decode, ID/EX/MEM/WB control registers, load-use stall
// FSM and PC/IF-ID control. CTRL_BRANCH_EN enables beq/bne resolved in EX via alu_zero.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned ALU_SEL_W    = 4,
  parameter int unsigned STALL_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
`ifdef CTRL_BRANCH_EN
  input  logic                  alu_zero,
`endif
  output logic                  pc_enable,
  output logic [1:0]            sel_pc_mux,
  output logic                  if_id_enable,
  output logic                  if_id_flush,
  output logic                  stall,
  output logic [1:0]            ex_mux_1,
  output logic                  ex_mux_3,
  output logic [ALU_SEL_W-1:0]  ex_sel_alu,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  wb_mux_2,
  output logic                  wb_banco_wr,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic                  illegal_op
);

  // The detection cycle is the first bubble, so the STALL state covers the remaining ones.
  localparam logic [1:0] CntInit = (STALL_CYCLES > 1) ? 2'(STALL_CYCLES - 2) : 2'd0;

  ctrl_bundle_t          id_bundle, id_gated, ex_d, ex_q;
  mem_stage_t            mem_q;
  wb_ctrl_t              wb_q;
  logic [REG_ADDR_W-1:0] id_dest, ex_dest_d, ex_dest_q, mem_dest_q, wb_dest_q;
  logic                  reads_rs, reads_rt, is_jump;
  logic                  hazard, branch_taken, stall_now, jump_now;
  ctrl_state_e           state_d, state_q;
  logic [1:0]            cnt_d, cnt_q;

  ctrl_decoder u_decoder (
    .opcode   (opcode),
    .funct    (funct),
    .bundle   (id_bundle),
    .reads_rs (reads_rs),
    .reads_rt (reads_rt),
    .is_jump  (is_jump)
  );

  assign id_dest = (id_bundle.ex.mux_3 == DestRt) ? rt : rd;

  always_comb begin
    id_gated = id_bundle;
    if (id_dest == '0) id_gated.wb.banco_wr = 1'b0;
  end

  assign hazard = instr_valid && ex_q.mem.rd && (ex_dest_q != '0) &&
                  ((reads_rs && (ex_dest_q == rs)) || (reads_rt && (ex_dest_q == rt)));

`ifdef CTRL_BRANCH_EN
  assign branch_taken = ex_q.ex.is_branch && (alu_zero ^ ex_q.ex.branch_ne);
`else
  assign branch_taken = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_now = 1'b0;
    case (state_q)
      StRun: begin
        if (hazard && !branch_taken) begin
          stall_now = 1'b1;
          if (STALL_CYCLES > 1) begin
            state_d = StStall;
            cnt_d   = CntInit;
          end
        end
      end
      StStall: begin
        if (branch_taken) begin
          state_d = StRun;
          cnt_d   = 2'd0;
        end else begin
          stall_now = 1'b1;
          if (cnt_q == 2'd0) state_d = StRun;
          else               cnt_d   = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = 2'd0;
      end
    endcase
  end

  assign jump_now = instr_valid && is_jump && !stall_now && !branch_taken;

  always_comb begin
    pc_enable    = !rst && !stall_now;
    if_id_enable = !rst && !stall_now;
    stall        = !rst && stall_now;
    if_id_flush  = !rst && (branch_taken || jump_now);
    sel_pc_mux   = PcPlus4;
    if (!rst) begin
      if (branch_taken)  sel_pc_mux = PcBranch;
      else if (jump_now) sel_pc_mux = PcJump;
    end
  end

  always_comb begin
    ex_d      = id_gated;
    ex_dest_d = id_dest;
    if (stall_now || !instr_valid || branch_taken) begin
      ex_d      = '0;
      ex_dest_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      cnt_q      <= 2'd0;
      ex_q       <= '0;
      ex_dest_q  <= '0;
      mem_q      <= '0;
      mem_dest_q <= '0;
      wb_q       <= '0;
      wb_dest_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_q       <= ex_d;
      ex_dest_q  <= ex_dest_d;
      mem_q      <= '{mem: ex_q.mem, wb: ex_q.wb};
      mem_dest_q <= ex_dest_q;
      wb_q       <= mem_q.wb;
      wb_dest_q  <= mem_dest_q;
    end
  end

  assign ex_mux_1    = ex_q.ex.mux_1;
  assign ex_mux_3    = ex_q.ex.mux_3;
  assign ex_sel_alu  = ALU_SEL_W'(ex_q.ex.sel_alu);
  assign illegal_op  = ex_q.ex.illegal;
  assign mem_rd      = mem_q.mem.rd;
  assign mem_wr      = mem_q.mem.wr;
  assign wb_mux_2    = wb_q.mux_2;
  assign wb_banco_wr = wb_q.banco_wr;
  assign wb_dest     = wb_dest_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit (two-cycle load-use stall build).
// Branch vectors run only when CTRL_BRANCH_EN is defined.
module tb_pipe_ctrl_unit;

  localparam int unsigned Stall = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
`ifdef CTRL_BRANCH_EN
  logic       alu_zero;
`endif
  logic       pc_enable, if_id_enable, if_id_flush, stall;
  logic [1:0] sel_pc_mux, ex_mux_1;
  logic       ex_mux_3, mem_rd, mem_wr, wb_mux_2, wb_banco_wr, illegal_op;
  logic [3:0] ex_sel_alu;
  logic [4:0] wb_dest;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] alu;
    logic [1:0] m1;
    logic       m3;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  pipe_ctrl_unit #(
    .REG_ADDR_W   (5),
    .ALU_SEL_W    (4),
    .STALL_CYCLES (Stall)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .opcode       (opcode),
    .funct        (funct),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
`ifdef CTRL_BRANCH_EN
    .alu_zero     (alu_zero),
`endif
    .pc_enable    (pc_enable),
    .sel_pc_mux   (sel_pc_mux),
    .if_id_enable (if_id_enable),
    .if_id_flush  (if_id_flush),
    .stall        (stall),
    .ex_mux_1     (ex_mux_1),
    .ex_mux_3     (ex_mux_3),
    .ex_sel_alu   (ex_sel_alu),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .wb_mux_2     (wb_mux_2),
    .wb_banco_wr  (wb_banco_wr),
    .wb_dest      (wb_dest),
    .illegal_op   (illegal_op)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    instr_valid = v;
    opcode      = op;
    funct       = fn;
    rs          = s;
    rt          = t;
    rd          = d;
    #1;
  endtask

  task automatic nop;
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    vecs[0] = '{op: 6'h00, fn: 6'h20, alu: 4'h0, m1: 2'd0, m3: 1'b0};
    vecs[1] = '{op: 6'h00, fn: 6'h22, alu: 4'h1, m1: 2'd0, m3: 1'b0};
    vecs[2] = '{op: 6'h00, fn: 6'h24, alu: 4'h8, m1: 2'd0, m3: 1'b0};
    vecs[3] = '{op: 6'h00, fn: 6'h25, alu: 4'h9, m1: 2'd0, m3: 1'b0};
    vecs[4] = '{op: 6'h00, fn: 6'h27, alu: 4'hD, m1: 2'd0, m3: 1'b0};
    vecs[5] = '{op: 6'h00, fn: 6'h00, alu: 4'h2, m1: 2'd2, m3: 1'b0};
    vecs[6] = '{op: 6'h00, fn: 6'h02, alu: 4'h3, m1: 2'd2, m3: 1'b0};
    vecs[7] = '{op: 6'h08, fn: 6'h00, alu: 4'h0, m1: 2'd1, m3: 1'b1};
    vecs[8] = '{op: 6'h0C, fn: 6'h00, alu: 4'h8, m1: 2'd1, m3: 1'b1};
    vecs[9] = '{op: 6'h0D, fn: 6'h00, alu: 4'h9, m1: 2'd1, m3: 1'b1};

    rst = 1'b1;
`ifdef CTRL_BRANCH_EN
    alu_zero = 1'b0;
`endif
    nop;
    #2;
    check("rst_pc_enable", 32'(pc_enable), 32'd0);
    check("rst_if_id_enable", 32'(if_id_enable), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_sel_pc", 32'(sel_pc_mux), 32'd0);
    check("rst_flush", 32'(if_id_flush), 32'd0);
    check("rst_wb_wr", 32'(wb_banco_wr), 32'd0);
    tick;
    tick;
    rst = 1'b0;
    #1;
    check("run_pc_enable", 32'(pc_enable), 32'd1);
    check("run_if_id_enable", 32'(if_id_enable), 32'd1);

    // ALU decode table
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].fn, 5'd1, 5'd2, 5'd3);
      tick;
      nop;
      check($sformatf("dec%0d_alu", i), 32'(ex_sel_alu), 32'(vecs[i].alu));
      check($sformatf("dec%0d_mux1", i), 32'(ex_mux_1), 32'(vecs[i].m1));
      check($sformatf("dec%0d_mux3", i), 32'(ex_mux_3), 32'(vecs[i].m3));
    end
    tick;
    tick;

    // add r3 then or r4 through to writeback
    drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3);
    tick;
    check("add_ex_alu", 32'(ex_sel_alu), 32'd0);
    check("add_ex_mux3", 32'(ex_mux_3), 32'd0);
    drive(1'b1, 6'h00, 6'h25, 5'd1, 5'd2, 5'd4);
    tick;
    check("or_ex_alu", 32'(ex_sel_alu), 32'd9);
    check("add_mem_rd", 32'(mem_rd), 32'd0);
    nop;
    tick;
    check("add_wb_wr", 32'(wb_banco_wr), 32'd1);
    check("add_wb_dest", 32'(wb_dest), 32'd3);
    check("add_wb_mux2", 32'(wb_mux_2), 32'd1);
    tick;
    check("or_wb_dest", 32'(wb_dest), 32'd4);

    // addi to r0 must not write
    drive(1'b1, 6'h08, 6'h00, 5'd1, 5'd0, 5'd0);
    tick;
    nop;
    tick;
    tick;
    check("r0_wb_wr", 32'(wb_banco_wr), 32'd0);
    check("r0_wb_mux2", 32'(wb_mux_2), 32'd1);
    tick;

    // lw r5 then sub r6,r5,r2: load-use stall
    drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
    check("lw_no_stall", 32'(stall), 32'd0);
    tick;
    drive(1'b1, 6'h00, 6'h22, 5'd5, 5'd2, 5'd6);
    check("lu_pc_enable", 32'(pc_enable), 32'd0);
    check("lu_if_id_enable", 32'(if_id_enable), 32'd0);
    cnt = 0;
    while (stall && cnt < 8) begin
      cnt++;
      tick;
    end
    check("lu_stall_len", 32'(cnt), 32'(Stall));
    check("lu_pc_resume", 32'(pc_enable), 32'd1);
    check("lw_wb_mux2", 32'(wb_mux_2), 32'd0);
    check("lw_wb_wr", 32'(wb_banco_wr), 32'd1);
    check("lw_wb_dest", 32'(wb_dest), 32'd5);
    tick;
    nop;
    check("lu_sub_ex", 32'(ex_sel_alu), 32'd1);
    tick;
    tick;

    // sw reads rt: hazard on rt
    drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
    tick;
    drive(1'b1, 6'h2B, 6'h00, 5'd1, 5'd5, 5'd0);
    check("sw_rt_hazard", 32'(stall), 32'd1);
    nop;
    tick;
    // addi's rt is its destination, not a source
    drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
    tick;
    drive(1'b1, 6'h08, 6'h00, 5'd1, 5'd5, 5'd0);
    check("addi_rt_no_haz", 32'(stall), 32'd0);
    tick;
    // lw r0 never hazards
    drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd0, 5'd0);
    tick;
    drive(1'b1, 6'h00, 6'h22, 5'd0, 5'd2, 5'd6);
    check("dest0_no_haz", 32'(stall), 32'd0);
    tick;
    // invalid ID slot never hazards
    drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
    tick;
    drive(1'b0, 6'h00, 6'h22, 5'd5, 5'd5, 5'd6);
    check("invalid_no_haz", 32'(stall), 32'd0);
    tick;

    // lw r5 then j (rs field 5): no stall, jump redirect + flush
    drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
    tick;
    drive(1'b1, 6'h02, 6'h00, 5'd5, 5'd5, 5'd5);
    check("j_no_stall", 32'(stall), 32'd0);
    check("j_sel_pc", 32'(sel_pc_mux), 32'd1);
    check("j_flush", 32'(if_id_flush), 32'd1);
    tick;
    nop;
    check("j_sel_pc_after", 32'(sel_pc_mux), 32'd0);
    check("j_flush_after", 32'(if_id_flush), 32'd0);
    tick;
    tick;
    check("j_wb_wr", 32'(wb_banco_wr), 32'd0);
    tick;

    // illegal opcode 3F
    drive(1'b1, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3);
    check("ill_not_yet", 32'(illegal_op), 32'd0);
    tick;
    check("ill_pulse", 32'(illegal_op), 32'd1);
    nop;
    tick;
    check("ill_pulse_end", 32'(illegal_op), 32'd0);
    check("ill_mem_rd", 32'(mem_rd), 32'd0);
    check("ill_mem_wr", 32'(mem_wr), 32'd0);
    tick;
    check("ill_wb_wr", 32'(wb_banco_wr), 32'd0);
    // illegal R-type funct
    drive(1'b1, 6'h00, 6'h3F, 5'd1, 5'd2, 5'd3);
    tick;
    nop;
    check("ill_funct", 32'(illegal_op), 32'd1);
    tick;
    tick;
    check("ill_funct_wb_wr", 32'(wb_banco_wr), 32'd0);
    tick;

    // reset while in the stall state
    drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
    tick;
    drive(1'b1, 6'h00, 6'h22, 5'd5, 5'd2, 5'd6);
    tick;
    check("pre_rst_stall", 32'(stall), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_pc_enable", 32'(pc_enable), 32'd0);
    check("mid_rst_if_id_en", 32'(if_id_enable), 32'd0);
    check("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
    tick;
    rst = 1'b0;
    #1;
    check("post_rst_stall", 32'(stall), 32'd0);
    check("post_rst_pc_enable", 32'(pc_enable), 32'd1);
    nop;
    tick;

`ifdef CTRL_BRANCH_EN
    // beq taken
    drive(1'b1, 6'h04, 6'h00, 5'd1, 5'd2, 5'd0);
    tick;
    drive(1'b1, 6'h00, 6'h22, 5'd1, 5'd2, 5'd6);
    alu_zero = 1'b1;
    #1;
    check("beq_t_sel_pc", 32'(sel_pc_mux), 32'd2);
    check("beq_t_flush", 32'(if_id_flush), 32'd1);
    tick;
    alu_zero = 1'b0;
    nop;
    check("beq_t_ex_nop", 32'(ex_sel_alu), 32'd0);
    tick;
    // beq not taken
    drive(1'b1, 6'h04, 6'h00, 5'd1, 5'd2, 5'd0);
    tick;
    drive(1'b1, 6'h00, 6'h22, 5'd1, 5'd2, 5'd6);
    check("beq_nt_sel_pc", 32'(sel_pc_mux), 32'd0);
    check("beq_nt_flush", 32'(if_id_flush), 32'd0);
    tick;
    nop;
    check("beq_nt_ex_sub", 32'(ex_sel_alu), 32'd1);
    tick;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
